// File: rtl/misr_compactor.sv
// -----------------------------------------------------------------------------
// misr_compactor
//
// Multiple-input signature register (MISR) that compacts a fixed-length
// window of samples from an upstream 4-bit counter into one signature. A
// test controller pulses start. The block then folds WINDOW qualified
// samples {co_in, data_in} into the signature. It stops in DONE and shows
// whether the result matches GOLDEN.
//
// Parameters
//   WIDTH   signature register width (5..32)
//   POLY    feedback taps; bit i set = tap at stage i
//   SEED    signature value loaded at the start of every run
//   WINDOW  valid samples compacted per run (1..65535)
//   GOLDEN  expected final signature
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   start      in   run request pulse (ignored while a run is in progress)
//   valid_in   in   sample qualifier (upstream counter enable)
//   data_in    in   upstream counter[3:0]
//   co_in      in   upstream carry-out
//   busy       out  high while compacting (RUN)
//   done       out  high once the window is complete (DONE)
//   pass       out  final signature equals GOLDEN; only ever high with done
//   signature  out  current MISR contents
// -----------------------------------------------------------------------------
module misr_compactor #(
  parameter int unsigned       WIDTH  = 8,
  parameter logic [WIDTH-1:0]  POLY   = WIDTH'(8'h1D),
  parameter logic [WIDTH-1:0]  SEED   = WIDTH'(8'h00),
  parameter int unsigned       WINDOW = 16,
  parameter logic [WIDTH-1:0]  GOLDEN = WIDTH'(8'h00)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             valid_in,
  input  logic [3:0]       data_in,
  input  logic             co_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature
);

  // The counter has to hold the value WINDOW itself (reached on the last
  // sample), so it never wraps inside a run.
  localparam int unsigned      CNT_W    = $clog2(WINDOW + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Encoding 2'b11 is unreachable; the default branch below recovers it.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sig_q,   sig_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             pass_q,  pass_d;

  logic [WIDTH-1:0] sample;
  logic [WIDTH-1:0] sig_next;

  // Five-bit sample vector, zero-extended to the register width.
  always_comb begin
    sample      = '0;
    sample[4:0] = {co_in, data_in};
  end

  // One MISR step: shift left and apply the polynomial when the MSB falls
  // off. Then XOR in the parallel sample.
  assign sig_next = {sig_q[WIDTH-2:0], 1'b0}
                  ^ (sig_q[WIDTH-1] ? POLY : '0)
                  ^ sample;

  // NOTE: every signal written here gets a default first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;

    case (state_q)
      IDLE: begin
        pass_d = 1'b0;
        // A sample presented together with start is deliberately dropped.
        // Compaction begins on the following cycle.
        if (start) begin
          state_d = RUN;
          sig_d   = SEED;
          cnt_d   = '0;
        end
      end

      RUN: begin
        // start is ignored here: a run is neither restarted nor aborted.
        pass_d = 1'b0;
        if (valid_in) begin
          sig_d = sig_next;
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == LAST_CNT) begin
            state_d = DONE;
            // Compare against the value being loaded so that pass rises
            // on the same edge as done.
            pass_d  = (sig_next == GOLDEN);
          end
        end
      end

      DONE: begin
        // Hold the result until the controller asks for another run.
        if (start) begin
          state_d = RUN;
          sig_d   = SEED;
          cnt_d   = '0;
          pass_d  = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        pass_d  = 1'b0;
      end
    endcase
  end

  // rst asserts asynchronously. Its release is assumed to be already
  // aligned to clk upstream, so the first edge after release acts on the
  // inputs without an extra synchroniser delay.
  // NOTE: state registers use non-blocking assignments so that every flop
  // samples the pre-edge values, whatever order the simulator evaluates in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sig_q   <= SEED;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign pass      = pass_q;
  assign signature = sig_q;

endmodule

// File: tb/tb_misr_compactor.sv
// -----------------------------------------------------------------------------
// tb_misr_compactor
//
// Five instances share one set of stimulus inputs:
//   0: WINDOW=1,  SEED=00, GOLDEN=05
//   1: WINDOW=2,  SEED=00, GOLDEN=00
//   2: WINDOW=1,  SEED=80, GOLDEN=00
//   3: WINDOW=16, SEED=00, GOLDEN=model result of a full counter run
//   4: WINDOW=16, SEED=00, GOLDEN=model result XOR 01
// A per-cycle vector table exercises the short-window instances. Hand-written
// sequences then cover the 16-sample runs, a mid-run reset and DONE hold and
// restart.
// -----------------------------------------------------------------------------
module tb_misr_compactor;

  // Software model of one MISR step with x^8+x^4+x^3+x^2+1.
  function automatic logic [7:0] model_step(input logic [7:0] s, input logic [4:0] v);
    return {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00) ^ {3'b000, v};
  endfunction

  // Upstream counter counting 0..F, with co_in high on F.
  function automatic logic [7:0] model_count_run();
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < 16; i++) begin
      s = model_step(s, {(i == 15), 4'(i)});
    end
    return s;
  endfunction

  localparam logic [7:0] GOLD = model_count_run();

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       valid_in = 1'b0;
  logic [3:0] data_in = 4'h0;
  logic       co_in = 1'b0;

  logic [7:0] sig_w  [5];
  logic       busy_w [5];
  logic       done_w [5];
  logic       pass_w [5];

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  misr_compactor #(.WINDOW(1), .SEED(8'h00), .GOLDEN(8'h05)) u_w1_s00 (
    .clk(clk), .rst(rst), .start(start), .valid_in(valid_in), .data_in(data_in),
    .co_in(co_in), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
    .signature(sig_w[0]));

  misr_compactor #(.WINDOW(2), .SEED(8'h00), .GOLDEN(8'h00)) u_w2_s00 (
    .clk(clk), .rst(rst), .start(start), .valid_in(valid_in), .data_in(data_in),
    .co_in(co_in), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
    .signature(sig_w[1]));

  misr_compactor #(.WINDOW(1), .SEED(8'h80), .GOLDEN(8'h00)) u_w1_s80 (
    .clk(clk), .rst(rst), .start(start), .valid_in(valid_in), .data_in(data_in),
    .co_in(co_in), .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
    .signature(sig_w[2]));

  misr_compactor #(.WINDOW(16), .SEED(8'h00), .GOLDEN(GOLD)) u_w16_good (
    .clk(clk), .rst(rst), .start(start), .valid_in(valid_in), .data_in(data_in),
    .co_in(co_in), .busy(busy_w[3]), .done(done_w[3]), .pass(pass_w[3]),
    .signature(sig_w[3]));

  misr_compactor #(.WINDOW(16), .SEED(8'h00), .GOLDEN(GOLD ^ 8'h01)) u_w16_bad (
    .clk(clk), .rst(rst), .start(start), .valid_in(valid_in), .data_in(data_in),
    .co_in(co_in), .busy(busy_w[4]), .done(done_w[4]), .pass(pass_w[4]),
    .signature(sig_w[4]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic check_dut(input int idx, input string tag, input logic [7:0] e_sig,
                           input logic e_busy, input logic e_done, input logic e_pass);
    check($sformatf("%s dut%0d signature", tag, idx), 32'(sig_w[idx]),  32'(e_sig));
    check($sformatf("%s dut%0d busy", tag, idx),      32'(busy_w[idx]), 32'(e_busy));
    check($sformatf("%s dut%0d done", tag, idx),      32'(done_w[idx]), 32'(e_done));
    check($sformatf("%s dut%0d pass", tag, idx),      32'(pass_w[idx]), 32'(e_pass));
  endtask

  // Inputs change on the falling edge. Outputs are sampled 1 time unit
  // after the following rising edge.
  task automatic cycle(input logic s, input logic v, input logic [3:0] d, input logic c);
    @(negedge clk);
    start    = s;
    valid_in = v;
    data_in  = d;
    co_in    = c;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit         tick;   // 1: apply inputs and clock; 0: check only
    bit         st;
    bit         vl;
    logic [3:0] dat;
    bit         co;
    int         dut;
    logic [7:0] sig;
    bit         busy;
    bit         done;
    bit         pass;
  } vec_t;

  vec_t vecs [16];

  initial begin
    // tick st vl dat  co dut sig    busy done pass
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 4'h5, 1'b0, 0, 8'h00, 1'b1, 1'b0, 1'b0}; // start+valid: sample dropped
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 4'h5, 1'b0, 0, 8'h05, 1'b0, 1'b1, 1'b1}; // W=1 done next cycle
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 4'h6, 1'b0, 0, 8'h05, 1'b0, 1'b1, 1'b1}; // DONE holds
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1, 8'h0C, 1'b0, 1'b1, 1'b0}; // W=2: 05 then 06
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1, 8'h00, 1'b1, 1'b0, 1'b0}; // restart from DONE
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 4'h1, 1'b0, 1, 8'h01, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 0, 8'h01, 1'b0, 1'b1, 1'b0}; // mismatch -> pass 0
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1, 8'h01, 1'b1, 1'b0, 1'b0}; // valid=0 holds
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 4'h2, 1'b0, 1, 8'h00, 1'b0, 1'b1, 1'b1}; // start in RUN ignored
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 0, 8'h00, 1'b1, 1'b0, 1'b0}; // restarted, sample dropped
    vecs[10] = '{1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 2, 8'h1D, 1'b0, 1'b1, 1'b0}; // SEED=80 MSB feedback
    vecs[11] = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 0, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 4'h7, 1'b1, 2, 8'h80, 1'b1, 1'b0, 1'b0}; // reload SEED
    vecs[13] = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 2, 8'h80, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 1'b1, 4'h0, 1'b1, 2, 8'h0D, 1'b0, 1'b1, 1'b0}; // co_in folds in bit 4
    vecs[15] = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 2, 8'h0D, 1'b0, 1'b1, 1'b0};

    // Reset state, held across two clock edges.
    repeat (2) @(posedge clk);
    #1;
    check_dut(0, "reset", 8'h00, 1'b0, 1'b0, 1'b0);
    check_dut(2, "reset", 8'h80, 1'b0, 1'b0, 1'b0);
    check_dut(3, "reset", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Short-window behaviour driven from the table.
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].tick) cycle(vecs[i].st, vecs[i].vl, vecs[i].dat, vecs[i].co);
      check_dut(vecs[i].dut, $sformatf("vec%0d", i),
                vecs[i].sig, vecs[i].busy, vecs[i].done, vecs[i].pass);
    end

    // Asynchronous reset from DONE: outputs clear before any clock edge.
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_dut(2, "async_rst_done", 8'h80, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // WINDOW=16 with valid toggling. start pulses during RUN have no effect.
    cycle(1'b1, 1'b0, 4'h0, 1'b0);
    check_dut(3, "w16_start", 8'h00, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b1, 4'(i), (i == 15));
      if (i < 15) begin
        check($sformatf("toggle done early s%0d", i), 32'(done_w[3]), 32'd0);
        cycle((i % 3) == 0, 1'b0, 4'hF, 1'b1);
        check($sformatf("toggle busy gap%0d", i), 32'(busy_w[3]), 32'd1);
      end
    end
    check_dut(3, "toggle_end", GOLD, 1'b0, 1'b1, 1'b1);
    check_dut(4, "toggle_end", GOLD, 1'b0, 1'b1, 1'b0);

    // Mid-run reset after five samples.
    cycle(1'b1, 1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 4'(i), 1'b0);
    check_dut(3, "pre_rst", 8'h02, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_dut(3, "async_rst_run", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    // Remains idle until start, even with samples arriving.
    cycle(1'b0, 1'b1, 4'h9, 1'b0);
    cycle(1'b0, 1'b1, 4'hA, 1'b0);
    check_dut(3, "idle_after_rst", 8'h00, 1'b0, 1'b0, 1'b0);

    // Full uninterrupted 16-cycle counter run.
    cycle(1'b1, 1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 4'(i), (i == 15));
    check_dut(3, "full_run", GOLD, 1'b0, 1'b1, 1'b1);
    check_dut(4, "full_run", GOLD, 1'b0, 1'b1, 1'b0);

    // DONE holds against further samples.
    cycle(1'b0, 1'b1, 4'hA, 1'b1);
    cycle(1'b0, 1'b1, 4'h3, 1'b0);
    check_dut(3, "done_hold", GOLD, 1'b0, 1'b1, 1'b1);

    // start in DONE restarts: SEED reloaded, pass drops with done.
    cycle(1'b1, 1'b1, 4'h3, 1'b0);
    check_dut(3, "restart", 8'h00, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 4'h3, 1'b0);
    check_dut(3, "restart_first", 8'h03, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/misr_compactor.md
MISR_COMPACTOR -- requirements
Module: misr_compactor

Interface
REQ-001 Parameter WIDTH, default 8: signature register width; legal range 5..32.
REQ-002 Parameter POLY, default 8'h1D: feedback polynomial taps, x^8+x^4+x^3+x^2+1; bit i set means tap at stage i.
REQ-003 Parameter SEED, default 8'h00: value loaded into the signature at the start of a run.
REQ-004 Parameter WINDOW, default 16: number of valid samples compacted per run; legal range 1..65535.
REQ-005 Parameter GOLDEN, default 8'h00: expected final signature.
REQ-006 Port clk, input, 1: single clock, rising-edge active.
REQ-007 Port rst, input, 1: asynchronous, active-high reset.
REQ-008 Port start, input, 1: run request pulse from the test controller.
REQ-009 Port valid_in, input, 1: sample qualifier; tied to the upstream counter's en.
REQ-010 Port data_in, input, 4: upstream counter[3:0] value.
REQ-011 Port co_in, input, 1: upstream carry-out co.
REQ-012 Port busy, output, 1: high while in RUN.
REQ-013 Port done, output, 1: high while in DONE.
REQ-014 Port pass, output, 1: signature == GOLDEN; meaningful only while done=1.
REQ-015 Port signature, output, WIDTH: current MISR contents.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN and DONE; busy = (state==RUN) and done = (state==DONE), both decoded from registered state.
REQ-017 In IDLE with start=1, the block SHALL, at the next edge, enter RUN, load signature with SEED and clear the sample count.
REQ-018 The sample vector SHALL be v = {co_in, data_in}, 5 bits, zero-extended to WIDTH.
REQ-019 In RUN with valid_in=1, the next signature SHALL be: (signature<<1, LSB 0) XOR (signature[WIDTH-1] ? POLY : 0) XOR v; the sample count SHALL then increment.
REQ-020 In RUN with valid_in=0, the signature and the count SHALL hold.
REQ-021 On the edge that compacts the WINDOW-th valid sample, the block SHALL enter DONE; latency from the last valid sample to done=1 is one cycle.
REQ-022 The sample counter SHALL be ceil(log2(WINDOW+1)) bits wide and SHALL never wrap within a run.
REQ-023 pass SHALL be registered so that it is coincident with done; pass SHALL be 0 whenever done=0.
REQ-024 DONE SHALL hold signature, done and pass stable until start=1; start in DONE SHALL restart exactly as in IDLE (REQ-017).
REQ-025 start in RUN SHALL be ignored; the run SHALL neither restart nor abort.
REQ-026 When start and valid_in are both 1 in IDLE or DONE, the sample on that cycle SHALL NOT be compacted; compaction begins the following cycle.
REQ-027 Unreachable state encodings SHALL return to IDLE on the next edge.

Reset
REQ-028 rst=1 SHALL immediately, without a clock edge, force state to IDLE, signature to SEED, the count to 0, and busy, done and pass to 0.
REQ-029 rst asserted mid-run SHALL discard the partial signature; after deassertion the block SHALL remain in IDLE until start.
REQ-030 Reset deassertion SHALL be synchronous to clk; the first edge after deassertion SHALL act on inputs normally.

Verification
REQ-031 WINDOW=1, SEED=00: start, then valid_in=1 with data_in=5 and co_in=0 -> next cycle signature=05, done=1, busy=0.
REQ-032 WINDOW=2, SEED=00: samples 1 then 2 -> signature=00; with GOLDEN=00, pass=1.
REQ-033 WINDOW=1, SEED=80: sample data_in=0, co_in=0 -> signature=1D, confirming MSB feedback.
REQ-034 WINDOW=16, valid_in toggling every other cycle: done asserts exactly one cycle after the 16th valid sample; start pulses during RUN have no effect.
REQ-035 rst pulsed mid-run after 5 samples: outputs clear asynchronously; a new run from start yields the same signature as an uninterrupted run on the same data.
REQ-036 Full 16-cycle run of the upstream counter (0..F, co_in=1 on F) compared against a software model: pass=1 with the model's GOLDEN and pass=0 with GOLDEN XOR 01.
